// File: rtl/alu_exec_stage.sv
// Four-state execute sequencer wrapped around an external combinational 16-bit ALU.
// Owns the general register file and the PSR; accepts one command every four cycles.
module alu_exec_stage #(
  parameter int WIDTH_DATA    = 16,
  parameter int WIDTH_CONTROL = 4,
  parameter int NUM_REGS      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [WIDTH_CONTROL-1:0]    cmd_control,
  input  logic                        cmd_use_carry,
  input  logic [$clog2(NUM_REGS)-1:0] cmd_rdest,
  input  logic [$clog2(NUM_REGS)-1:0] cmd_rsrc,
  input  logic                        cmd_imm_en,
  input  logic [WIDTH_DATA-1:0]       cmd_imm,
  output logic [WIDTH_DATA-1:0]       alu_a,
  output logic [WIDTH_DATA-1:0]       alu_b,
  output logic [WIDTH_CONTROL-1:0]    alu_control,
  output logic                        alu_carry_in,
  input  logic [WIDTH_DATA-1:0]       alu_result,
  input  logic                        alu_carry,
  input  logic                        alu_low,
  input  logic                        alu_over,
  input  logic                        alu_neg,
  input  logic                        alu_zero,
  output logic                        done,
  output logic                        err,
  output logic [4:0]                  psr,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [WIDTH_DATA-1:0]       dbg_data
);

  localparam logic [WIDTH_CONTROL-1:0] CTL_ADD  = WIDTH_CONTROL'(0);
  localparam logic [WIDTH_CONTROL-1:0] CTL_ADDU = WIDTH_CONTROL'(1);
  localparam logic [WIDTH_CONTROL-1:0] CTL_SUB  = WIDTH_CONTROL'(2);
  localparam logic [WIDTH_CONTROL-1:0] CTL_SUBU = WIDTH_CONTROL'(3);
  localparam logic [WIDTH_CONTROL-1:0] CTL_CMP  = WIDTH_CONTROL'(4);
  localparam logic [WIDTH_CONTROL-1:0] CTL_AND  = WIDTH_CONTROL'(5);
  localparam logic [WIDTH_CONTROL-1:0] CTL_OR   = WIDTH_CONTROL'(6);
  localparam logic [WIDTH_CONTROL-1:0] CTL_XOR  = WIDTH_CONTROL'(7);
  localparam logic [WIDTH_CONTROL-1:0] CTL_LSH  = WIDTH_CONTROL'(8);
  localparam logic [WIDTH_CONTROL-1:0] CTL_MOV  = WIDTH_CONTROL'(9);

  // PSR bit positions; the captured ALU flag vector uses the same ordering.
  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_N = 1;
  localparam int PSR_Z = 0;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t                        r_state;
  logic [WIDTH_DATA-1:0]         r_regs [NUM_REGS];
  logic [WIDTH_CONTROL-1:0]      r_control;
  logic                          r_useCarry;
  logic [$clog2(NUM_REGS)-1:0]   r_rdest;
  logic [$clog2(NUM_REGS)-1:0]   r_rsrc;
  logic                          r_immEn;
  logic [WIDTH_DATA-1:0]         r_imm;
  logic [WIDTH_DATA-1:0]         r_result;
  logic [4:0]                    r_flags;

  logic                          w_illegal;
  logic                          w_writes;
  logic [WIDTH_DATA-1:0]         w_wbData;

  assign w_illegal = (r_control > CTL_MOV);
  assign w_writes  = !w_illegal && (r_control != CTL_CMP);
  // MOV bypasses the ALU and stores the B operand as presented to it.
  assign w_wbData  = (r_control == CTL_MOV) ? alu_b : r_result;
  assign cmd_ready = (r_state == IDLE);
  assign dbg_data  = r_regs[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_control    <= '0;
      r_useCarry   <= 1'b0;
      r_rdest      <= '0;
      r_rsrc       <= '0;
      r_immEn      <= 1'b0;
      r_imm        <= '0;
      r_result     <= '0;
      r_flags      <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_control  <= '0;
      alu_carry_in <= 1'b0;
      psr          <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_control  <= cmd_control;
            r_useCarry <= cmd_use_carry;
            r_rdest    <= cmd_rdest;
            r_rsrc     <= cmd_rsrc;
            r_immEn    <= cmd_imm_en;
            r_imm      <= cmd_imm;
            r_state    <= READ;
          end
        end
        READ: begin
          alu_a        <= r_regs[r_rdest];
          alu_b        <= r_immEn ? r_imm : r_regs[r_rsrc];
          alu_control  <= r_control;
          alu_carry_in <= r_useCarry & psr[PSR_C];
          r_state      <= EXEC;
        end
        EXEC: begin
          r_result <= alu_result;
          r_flags  <= {alu_carry, alu_low, alu_over, alu_neg, alu_zero};
          r_state  <= WB;
        end
        WB: begin
          done <= 1'b1;
          err  <= w_illegal;
          if (w_writes) r_regs[r_rdest] <= w_wbData;
          case (r_control)
            CTL_ADD, CTL_SUB: begin
              psr[PSR_F] <= r_flags[PSR_F];
              psr[PSR_Z] <= r_flags[PSR_Z];
            end
            CTL_ADDU, CTL_SUBU: begin
              psr[PSR_C] <= r_flags[PSR_C];
              psr[PSR_Z] <= r_flags[PSR_Z];
            end
            CTL_CMP: begin
              psr[PSR_L] <= r_flags[PSR_L];
              psr[PSR_N] <= r_flags[PSR_N];
              psr[PSR_Z] <= r_flags[PSR_Z];
            end
            CTL_AND, CTL_OR, CTL_XOR, CTL_LSH: begin
              psr[PSR_Z] <= r_flags[PSR_Z];
            end
            default: begin
            end
          endcase
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: a stand-in ALU, a command-level reference
// model with a per-cycle compare process, and hand-computed literal checks.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_control = '0;
  logic        cmd_use_carry = 1'b0;
  logic [3:0]  cmd_rdest = '0;
  logic [3:0]  cmd_rsrc = '0;
  logic        cmd_imm_en = 1'b0;
  logic [15:0] cmd_imm = '0;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic        alu_carry_in;
  logic [15:0] alu_result;
  logic        alu_carry, alu_low, alu_over, alu_neg, alu_zero;
  logic        done, err;
  logic [4:0]  psr;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int nChecks = 0;
  int nFail = 0;
  int edgeCount = 0;
  bit checkEn = 1'b0;
  bit dbgHold = 1'b0;
  logic [3:0] dbgForce = '0;

  // Reference state: spec* is the architectural state after every issued command,
  // vis* is what the DUT must currently show; pend* is the one command in flight.
  logic [15:0] specRegs [16];
  logic [15:0] visRegs [16];
  logic [4:0]  specPsr, visPsr;
  bit          pendValid = 1'b0;
  int          pendIssue;
  logic        pendWen, pendErr, pendCin;
  logic [3:0]  pendIdx, pendCtl;
  logic [15:0] pendVal, pendA, pendB;
  logic [4:0]  pendPsr;

  alu_exec_stage dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_control(cmd_control), .cmd_use_carry(cmd_use_carry),
    .cmd_rdest(cmd_rdest), .cmd_rsrc(cmd_rsrc),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_low(alu_low),
    .alu_over(alu_over), .alu_neg(alu_neg), .alu_zero(alu_zero),
    .done(done), .err(err), .psr(psr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edgeCount++;
  always @(posedge clk) dbg_addr <= dbgHold ? dbgForce : dbg_addr + 4'd1;

  // Stand-in ALU: returns {result, C, L, F, N, Z}.
  function automatic logic [20:0] aluEval(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] c, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic cf, lf, ff, nf, zf;
    s = '0; cf = 1'b0; lf = 1'b0; ff = 1'b0; nf = 1'b0;
    case (c)
      4'd0, 4'd1: begin
        s = a + b + cin; r = s[15:0]; cf = s[16];
        ff = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd2, 4'd3: begin
        s = {1'b0, a} - {1'b0, b} - {16'd0, cin}; r = s[15:0]; cf = s[16];
        ff = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'd4: begin
        r = a - b; lf = (a < b); nf = ($signed(a) < $signed(b));
      end
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: r = a << b[3:0];
      default: r = b;
    endcase
    zf = (c == 4'd4) ? (a == b) : (r == 16'd0);
    nf = (c == 4'd4) ? nf : r[15];
    return {r, cf, lf, ff, nf, zf};
  endfunction

  assign {alu_result, alu_carry, alu_low, alu_over, alu_neg, alu_zero} =
         aluEval(alu_a, alu_b, alu_control, alu_carry_in);

  // Which PSR bits {C,L,F,N,Z} each control is allowed to update.
  function automatic logic [4:0] flagMask(input logic [3:0] c);
    case (c)
      4'd0, 4'd2:             return 5'b00101;
      4'd1, 4'd3:             return 5'b10001;
      4'd4:                   return 5'b01011;
      4'd5, 4'd6, 4'd7, 4'd8: return 5'b00001;
      default:                return 5'b00000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelIssue(input logic [3:0] ctl, input logic useC, input logic [3:0] rd,
                            input logic [3:0] rs, input logic immEn, input logic [15:0] imm);
    logic [20:0] res;
    logic [4:0]  mask;
    pendA   = specRegs[rd];
    pendB   = immEn ? imm : specRegs[rs];
    pendCin = useC & specPsr[4];
    pendCtl = ctl;
    res     = aluEval(pendA, pendB, ctl, pendCin);
    mask    = flagMask(ctl);
    pendErr = (ctl > 4'd9);
    pendWen = !pendErr && (ctl != 4'd4);
    pendIdx = rd;
    pendVal = (ctl == 4'd9) ? pendB : res[20:5];
    pendPsr = (specPsr & ~mask) | (res[4:0] & mask);
    if (pendWen) specRegs[rd] = pendVal;
    specPsr   = pendPsr;
    pendIssue = edgeCount;
    pendValid = 1'b1;
  endtask

  task automatic applyStimulus(input logic [3:0] ctl, input logic useC, input logic [3:0] rd,
                               input logic [3:0] rs, input logic immEn, input logic [15:0] imm,
                               input bit keepValid);
    int budget;
    cmd_control = ctl; cmd_use_carry = useC; cmd_rdest = rd; cmd_rsrc = rs;
    cmd_imm_en = immEn; cmd_imm = imm; cmd_valid = 1'b1;
    budget = 0;
    while (!cmd_ready && budget < 20) begin
      @(posedge clk); #2;
      budget++;
    end
    if (!cmd_ready) begin
      checkOutput("handshake_timeout", {15'd0, cmd_ready}, 16'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #2;
    modelIssue(ctl, useC, rd, rs, immEn, imm);
    if (!keepValid) cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int budget;
    budget = 0;
    while (!cmd_ready && budget < 20) begin
      @(posedge clk); #2;
      budget++;
    end
    if (!cmd_ready) checkOutput("idle_timeout", {15'd0, cmd_ready}, 16'd1);
  endtask

  task automatic checkReg(input string name, input logic [3:0] idx, input logic [15:0] expected);
    waitIdle();
    dbgForce = idx;
    dbgHold  = 1'b1;
    @(posedge clk); #2;
    checkOutput(name, dbg_data, expected);
    dbgHold = 1'b0;
  endtask

  task automatic checkPsr(input string name, input logic [4:0] expected);
    waitIdle();
    checkOutput(name, {11'd0, psr}, {11'd0, expected});
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    pendValid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      specRegs[i] = '0;
      visRegs[i]  = '0;
    end
    specPsr = '0;
    visPsr  = '0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // Per-cycle comparison of every observable output against the reference model.
  always @(negedge clk) begin
    bit expDone, expReady, expErr;
    if (checkEn) begin
      expReady = !(pendValid && edgeCount < pendIssue + 3);
      expDone  = pendValid && (edgeCount == pendIssue + 3);
      expErr   = expDone && pendErr;
      if (pendValid && edgeCount == pendIssue + 1) begin
        checkOutput("alu_a", alu_a, pendA);
        checkOutput("alu_b", alu_b, pendB);
        checkOutput("alu_control", {12'd0, alu_control}, {12'd0, pendCtl});
        checkOutput("alu_carry_in", {15'd0, alu_carry_in}, {15'd0, pendCin});
      end
      if (expDone) begin
        if (pendWen) visRegs[pendIdx] = pendVal;
        visPsr    = pendPsr;
        pendValid = 1'b0;
      end
      if (rst_n) checkOutput("cmd_ready", {15'd0, cmd_ready}, {15'd0, expReady});
      checkOutput("done", {15'd0, done}, {15'd0, expDone});
      checkOutput("err", {15'd0, err}, {15'd0, expErr});
      checkOutput("psr", {11'd0, psr}, {11'd0, visPsr});
      checkOutput("dbg_data", dbg_data, visRegs[dbg_addr]);
    end
  end

  initial begin
    #1;
    applyReset();
    checkEn = 1'b1;
    checkOutput("reset_psr", {11'd0, psr}, 16'd0);
    checkOutput("reset_done", {15'd0, done}, 16'd0);
    checkOutput("reset_alu_a", alu_a, 16'd0);
    checkOutput("reset_alu_b", alu_b, 16'd0);
    checkOutput("reset_ready", {15'd0, cmd_ready}, 16'd1);

    // MOV immediates
    applyStimulus(4'd9, 1'b0, 4'd1, 4'd0, 1'b1, 16'h0005, 1'b0);
    applyStimulus(4'd9, 1'b0, 4'd2, 4'd0, 1'b1, 16'hFFFB, 1'b0);
    checkReg("mov_r1", 4'd1, 16'h0005);
    checkReg("mov_r2", 4'd2, 16'hFFFB);
    checkPsr("mov_psr", 5'b00000);

    // ADD to zero, then signed overflow
    applyStimulus(4'd0, 1'b0, 4'd1, 4'd2, 1'b0, 16'h0000, 1'b0);
    checkReg("add_r1", 4'd1, 16'h0000);
    checkPsr("add_z_psr", 5'b00001);
    applyStimulus(4'd9, 1'b0, 4'd3, 4'd0, 1'b1, 16'h7FFF, 1'b0);
    applyStimulus(4'd0, 1'b0, 4'd3, 4'd0, 1'b1, 16'h0001, 1'b0);
    checkReg("add_ovf_r3", 4'd3, 16'h8000);
    checkPsr("add_ovf_psr", 5'b00100);

    // ADDU carry out, then carry chained in
    applyStimulus(4'd9, 1'b0, 4'd7, 4'd0, 1'b1, 16'hFFFF, 1'b0);
    applyStimulus(4'd1, 1'b1, 4'd7, 4'd0, 1'b1, 16'h0001, 1'b0);
    checkReg("addu_r7", 4'd7, 16'h0000);
    checkPsr("addu_c_psr", 5'b10101);
    applyStimulus(4'd9, 1'b0, 4'd8, 4'd0, 1'b1, 16'h0000, 1'b0);
    applyStimulus(4'd1, 1'b1, 4'd8, 4'd0, 1'b1, 16'h0000, 1'b0);
    checkReg("addu_cin_r8", 4'd8, 16'h0001);
    checkPsr("addu_cin_psr", 5'b00100);

    // CMP does not write
    applyStimulus(4'd9, 1'b0, 4'd4, 4'd0, 1'b1, 16'h0003, 1'b0);
    applyStimulus(4'd9, 1'b0, 4'd5, 4'd0, 1'b1, 16'h0009, 1'b0);
    applyStimulus(4'd4, 1'b0, 4'd4, 4'd5, 1'b0, 16'h0000, 1'b0);
    checkReg("cmp_r4", 4'd4, 16'h0003);
    checkPsr("cmp_psr", 5'b01110);

    // Illegal control with cmd_valid held across busy states
    applyStimulus(4'hC, 1'b0, 4'd4, 4'd5, 1'b0, 16'h0000, 1'b1);
    applyStimulus(4'hC, 1'b0, 4'd4, 4'd5, 1'b0, 16'h0000, 1'b0);
    checkReg("illegal_r4", 4'd4, 16'h0003);
    checkReg("illegal_r5", 4'd5, 16'h0009);
    checkPsr("illegal_psr", 5'b01110);

    // Reset during EXEC of an AND
    applyStimulus(4'd9, 1'b0, 4'd6, 4'd0, 1'b1, 16'h1234, 1'b0);
    checkReg("pre_rst_r6", 4'd6, 16'h1234);
    applyStimulus(4'd5, 1'b0, 4'd6, 4'd0, 1'b1, 16'hFFFF, 1'b0);
    @(posedge clk); #2;
    applyReset();
    checkOutput("post_rst_ready", {15'd0, cmd_ready}, 16'd1);
    checkReg("post_rst_r6", 4'd6, 16'h0000);
    checkPsr("post_rst_psr", 5'b00000);

    // SUB, SUBU, LSH, XOR after reset
    applyStimulus(4'd9, 1'b0, 4'd1, 4'd0, 1'b1, 16'h8000, 1'b0);
    applyStimulus(4'd2, 1'b0, 4'd1, 4'd0, 1'b1, 16'h0001, 1'b0);
    checkReg("sub_r1", 4'd1, 16'h7FFF);
    checkPsr("sub_psr", 5'b00100);
    applyStimulus(4'd3, 1'b0, 4'd2, 4'd0, 1'b1, 16'h0001, 1'b0);
    checkReg("subu_r2", 4'd2, 16'hFFFF);
    checkPsr("subu_psr", 5'b10100);
    applyStimulus(4'd9, 1'b0, 4'd3, 4'd0, 1'b1, 16'h0001, 1'b0);
    applyStimulus(4'd8, 1'b0, 4'd3, 4'd0, 1'b1, 16'h0004, 1'b0);
    checkReg("lsh_r3", 4'd3, 16'h0010);
    applyStimulus(4'd7, 1'b0, 4'd3, 4'd3, 1'b0, 16'h0000, 1'b0);
    checkReg("xor_r3", 4'd3, 16'h0000);
    checkPsr("xor_psr", 5'b10101);

    repeat (4) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
